apu_sound_player: RTL and testbench
===================================

Name: apu_sound_player

Overview:
- Consumer end of the APU trigger interface. Takes the eat_sound, die_sound and hit_sound levels from the trigger block and plays a short fixed note sequence for each event on a 1-bit square-wave audio pin.
- Sits between the APU trigger block and the top-level audio output pin.
- Frame-synchronous note timing (frame_end) with cycle-accurate tone generation.

Parameters:
- NOTE_FRAMES, 6, number of frame_end pulses each note lasts (1..15).
- TONE_SHIFT, 0, right-shift applied to ROM half-periods; used to speed up simulation.
- DIV_W, 16, width of the tone half-period counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- frame_end  input  1  one-cycle pulse at the end of each video frame.
- eat_sound  input  1  eat trigger level from the APU trigger block.
- die_sound  input  1  die trigger level from the APU trigger block.
- hit_sound  input  1  hit trigger level from the APU trigger block.
- mute  input  1  forces sound low; sequencing continues.
- sound  output  1  square-wave audio output.
- busy  output  1  high while a sequence is playing.
- sound_id  output  2  0 none, 1 eat, 2 hit, 3 die.

Behaviour:
- Reset state: sound=0, busy=0, sound_id=0, FSM in IDLE, all counters=0, edge registers=0.
- Trigger detection:
  - Each trigger input is registered once.
  - start_x = x & ~x_q, a rising edge only. Held levels never restart a sequence.
- Priority when several edges arrive in one cycle: die > hit > eat.
- Preemption:
  - An edge whose priority is >= the current sound_id restarts playback with the new id.
  - A lower-priority edge while busy is dropped, not queued.
- FSM states: IDLE and PLAY.
  - IDLE -> PLAY on any accepted start. The same cycle loads note_idx=0, frame_cnt=0, tone_cnt=0, sound=0.
  - busy and sound_id are valid in the cycle after the start edge is seen on the input, i.e. one-cycle latency.
  - PLAY stays in PLAY while notes remain.
  - PLAY -> IDLE when the last note's frame count expires. That cycle clears busy, sound_id and sound.
- Note timing:
  - frame_cnt increments on each frame_end while in PLAY.
  - When frame_cnt==NOTE_FRAMES-1 and frame_end is high: frame_cnt <= 0 and note_idx advances.
  - Each note therefore lasts exactly NOTE_FRAMES frame_end pulses.
  - A frame_end that coincides with the start cycle is ignored for counting.
- Sequences: 4 notes each, note_idx 0..3. A ROM half-period value of 0 is a rest (sound held 0).
  - eat: 19073, 15138, 12727, 0.
  - hit: 28409, 0, 28409, 0.
  - die: 25310, 28409, 33784, 42561.
  - Effective half-period hp = rom >> TONE_SHIFT.
- Tone generation:
  - tone_cnt counts 0..hp-1. At hp-1 it wraps to 0 and sound toggles.
  - First toggle occurs hp cycles after the note loads.
  - On every note change tone_cnt resets to 0 and sound resets to 0.
  - If hp==0, including after the shift, the note is a rest: sound=0 and tone_cnt is held at 0.
- mute: the output is gated (sound = tone_level & ~mute). The internal tone phase keeps running.
- Reset mid-sequence returns to the reset state on the next edge and no sound is generated.
- Width rule: ROM entries are DIV_W bits; the shift saturates to 0 for large TONE_SHIFT.

Decomposition:
- Shared package apu_pkg:
  - sound id constants: SND_NONE=0, SND_EAT=1, SND_HIT=2, SND_DIE=3.
  - NOTES_PER_SEQ=4.
  - the three half-period tables as localparam arrays.
- Sub-module apu_note_rom: purely combinational; inputs sound_id and note_idx, output half-period.
- FSM, counters and edge detection live in apu_sound_player.

Test Plan:
- Eat sequence: NOTE_FRAMES=2, TONE_SHIFT=8. Pulse eat_sound high for 3 frames.
  - busy=1 and sound_id=1 one cycle after the edge.
  - sound toggles every 74 cycles (19073>>8).
  - Note 1 gives period 59, note 2 gives 49, note 3 holds sound at 0.
  - busy=0 after 8 frame_end pulses.
- Held level: hold eat_sound high across the whole sequence and beyond.
  - Exactly one sequence plays; no restart after busy falls.
- Simultaneous edges: eat, hit and die rise in the same cycle.
  - sound_id=3 and the die sequence plays (hp 98 with TONE_SHIFT=8).
- Priority handling:
  - Eat playing, then hit edge: sound_id becomes 2, note_idx=0, tone restarts.
  - Die playing, then eat edge: ignored and the die sequence completes.
- Mute: assert mute during hit note 0.
  - sound=0 for the mute duration.
  - Frame and note counters still advance; busy timing is unchanged.
- Reset mid-note: reset during die note 2.
  - Next cycle: sound=0, busy=0, sound_id=0.
  - A subsequent eat edge starts cleanly at note 0.

Source files
------------

// File: rtl/apu_pkg.sv
// ---------------------------------------------------------------------------
// apu_pkg
// Shared definitions for the APU sound path: sound id encoding, player FSM
// states, sequence length, the note half-period tables and a helper that
// resolves simultaneous trigger edges to a single sound id.
// ---------------------------------------------------------------------------
package apu_pkg;

  // Sound ids; numerically ordered by priority so ">=" means "may preempt".
  localparam logic [1:0] SND_NONE = 2'd0;
  localparam logic [1:0] SND_EAT  = 2'd1;
  localparam logic [1:0] SND_HIT  = 2'd2;
  localparam logic [1:0] SND_DIE  = 2'd3;

  localparam int NOTES_PER_SEQ = 4;

  // Half-periods in clock cycles; 0 marks a rest.
  localparam logic [15:0] EAT_HP [NOTES_PER_SEQ] = '{16'd19073, 16'd15138, 16'd12727, 16'd0};
  localparam logic [15:0] HIT_HP [NOTES_PER_SEQ] = '{16'd28409, 16'd0,     16'd28409, 16'd0};
  localparam logic [15:0] DIE_HP [NOTES_PER_SEQ] = '{16'd25310, 16'd28409, 16'd33784, 16'd42561};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } play_state_e;

  // Highest-priority sound among the edges seen this cycle (die > hit > eat).
  function automatic logic [1:0] pick_start(input logic die_s, input logic hit_s, input logic eat_s);
    logic [1:0] id_s;
    if (die_s) begin
      id_s = SND_DIE;
    end else if (hit_s) begin
      id_s = SND_HIT;
    end else if (eat_s) begin
      id_s = SND_EAT;
    end else begin
      id_s = SND_NONE;
    end
    return id_s;
  endfunction

endpackage

// File: rtl/apu_note_rom.sv
// ---------------------------------------------------------------------------
// apu_note_rom
// Combinational lookup of the tone half-period for a sound id and note index.
// Ports:
//   sound_id_i    [1:0]       sound being played (SND_NONE returns 0)
//   note_idx_i    [1:0]       note within the sequence
//   half_period_o [DIV_W-1:0] half-period in clock cycles (0 = rest)
// ---------------------------------------------------------------------------
module apu_note_rom
  import apu_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic [1:0]       sound_id_i,
  input  logic [1:0]       note_idx_i,
  output logic [DIV_W-1:0] half_period_o
);

  // Table select by sound id.
  always_comb begin
    half_period_o = '0;
    case (sound_id_i)
      SND_EAT: half_period_o = DIV_W'(EAT_HP[note_idx_i]);
      SND_HIT: half_period_o = DIV_W'(HIT_HP[note_idx_i]);
      SND_DIE: half_period_o = DIV_W'(DIE_HP[note_idx_i]);
      default: half_period_o = '0;
    endcase
  end

endmodule

// File: rtl/apu_sound_player.sv
// ---------------------------------------------------------------------------
// apu_sound_player
// Plays a fixed 4-note square-wave sequence for each rising edge of the
// eat/hit/die trigger levels. Notes last NOTE_FRAMES frame_end pulses; the
// tone half-period comes from apu_note_rom, shifted right by TONE_SHIFT.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   frame_end      one-cycle pulse per video frame (note timing)
//   eat/die/hit_sound  trigger levels
//   mute           gates sound low while the tone phase keeps running
//   sound          registered square-wave output
//   busy           high while a sequence plays
//   sound_id       0 none, 1 eat, 2 hit, 3 die
// ---------------------------------------------------------------------------
module apu_sound_player
  import apu_pkg::*;
#(
  parameter int NOTE_FRAMES = 6,
  parameter int TONE_SHIFT  = 0,
  parameter int DIV_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       eat_sound,
  input  logic       die_sound,
  input  logic       hit_sound,
  input  logic       mute,
  output logic       sound,
  output logic       busy,
  output logic [1:0] sound_id
);

  localparam logic [3:0] LAST_FRAME = 4'(NOTE_FRAMES - 1);
  localparam logic [1:0] LAST_NOTE  = 2'(NOTES_PER_SEQ - 1);

  play_state_e      state_q, state_d;
  logic             eat_q, die_q, hit_q;
  logic [1:0]       sound_id_q, sound_id_d;
  logic [1:0]       note_idx_q, note_idx_d;
  logic [3:0]       frame_cnt_q, frame_cnt_d;
  logic [DIV_W-1:0] tone_cnt_q, tone_cnt_d;
  logic             tone_lvl_q, tone_lvl_d;
  logic             sound_q, sound_d;
  logic             busy_q;
  logic [1:0]       start_id_s;
  logic             accept_s;
  logic [DIV_W-1:0] rom_hp_s, hp_s;

  apu_note_rom #(.DIV_W(DIV_W)) u_rom (
    .sound_id_i    (sound_id_q),
    .note_idx_i    (note_idx_q),
    .half_period_o (rom_hp_s)
  );

  // Shifting by DIV_W or more naturally yields 0, i.e. a rest.
  assign hp_s = rom_hp_s >> TONE_SHIFT;

  // Rising-edge detect on the raw levels; equal priority restarts playback.
  assign start_id_s = pick_start(die_sound & ~die_q, hit_sound & ~hit_q, eat_sound & ~eat_q);
  assign accept_s   = (start_id_s != SND_NONE) && (start_id_s >= sound_id_q);

  // Next-state logic for sequencing, note timing and tone generation.
  always_comb begin
    state_d     = state_q;
    sound_id_d  = sound_id_q;
    note_idx_d  = note_idx_q;
    frame_cnt_d = frame_cnt_q;
    tone_cnt_d  = tone_cnt_q;
    tone_lvl_d  = tone_lvl_q;
    if (accept_s) begin
      // A frame_end in the start cycle is deliberately not counted.
      state_d     = ST_PLAY;
      sound_id_d  = start_id_s;
      note_idx_d  = 2'd0;
      frame_cnt_d = 4'd0;
      tone_cnt_d  = '0;
      tone_lvl_d  = 1'b0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (frame_end && (frame_cnt_q == LAST_FRAME)) begin
            frame_cnt_d = 4'd0;
            tone_cnt_d  = '0;
            tone_lvl_d  = 1'b0;
            if (note_idx_q == LAST_NOTE) begin
              state_d    = ST_IDLE;
              sound_id_d = SND_NONE;
              note_idx_d = 2'd0;
            end else begin
              note_idx_d = note_idx_q + 2'd1;
            end
          end else begin
            if (frame_end) begin
              frame_cnt_d = frame_cnt_q + 4'd1;
            end else begin
              frame_cnt_d = frame_cnt_q;
            end
            if (hp_s == '0) begin
              tone_cnt_d = '0;
              tone_lvl_d = 1'b0;
            end else if (tone_cnt_q == (hp_s - DIV_W'(1))) begin
              tone_cnt_d = '0;
              tone_lvl_d = ~tone_lvl_q;
            end else begin
              tone_cnt_d = tone_cnt_q + DIV_W'(1);
            end
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    sound_d = tone_lvl_d & ~mute;
  end

  // State, counters, edge registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      eat_q       <= 1'b0;
      die_q       <= 1'b0;
      hit_q       <= 1'b0;
      sound_id_q  <= SND_NONE;
      note_idx_q  <= 2'd0;
      frame_cnt_q <= 4'd0;
      tone_cnt_q  <= '0;
      tone_lvl_q  <= 1'b0;
      sound_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      eat_q       <= eat_sound;
      die_q       <= die_sound;
      hit_q       <= hit_sound;
      sound_id_q  <= sound_id_d;
      note_idx_q  <= note_idx_d;
      frame_cnt_q <= frame_cnt_d;
      tone_cnt_q  <= tone_cnt_d;
      tone_lvl_q  <= tone_lvl_d;
      sound_q     <= sound_d;
      busy_q      <= (state_d == ST_PLAY);
    end
  end

  assign sound    = sound_q;
  assign busy     = busy_q;
  assign sound_id = sound_id_q;

endmodule

// File: tb/tb_apu_sound_player.sv
// Directed bench for apu_sound_player with NOTE_FRAMES=2, TONE_SHIFT=8.
// Effective half-periods: eat 74/59/49/rest, hit 110/rest/110/rest,
// die 98/110/131/166.
module tb_apu_sound_player;

  logic       clk;
  logic       reset;
  logic       frame_end;
  logic       eat_sound;
  logic       die_sound;
  logic       hit_sound;
  logic       mute;
  logic       sound;
  logic       busy;
  logic [1:0] sound_id;

  int n_cmp;
  int n_mis;
  logic saw_high;

  apu_sound_player #(.NOTE_FRAMES(2), .TONE_SHIFT(8), .DIV_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_end (frame_end),
    .eat_sound (eat_sound),
    .die_sound (die_sound),
    .hit_sound (hit_sound),
    .mute      (mute),
    .sound     (sound),
    .busy      (busy),
    .sound_id  (sound_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (sound) saw_high = 1'b1;
  endtask

  // Cycles until sound changes, bounded.
  task automatic measure_toggle(output int n);
    logic start_v;
    start_v = sound;
    n = 0;
    while (sound == start_v && n < 1000) begin
      step();
      n++;
    end
  endtask

  task automatic frame_pulses(input int cnt, input int gap);
    for (int i = 0; i < cnt; i++) begin
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
      repeat (gap) step();
    end
  endtask

  // Finish the current note; returns right after the note-change edge.
  task automatic next_note();
    frame_pulses(1, 3);
    frame_pulses(1, 0);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_id"}, int'(sound_id), 0);
    check_eq({tag, "_snd"}, int'(sound), 0);
  endtask

  initial begin
    int n;
    n_cmp = 0; n_mis = 0; saw_high = 1'b0;
    reset = 1'b1; frame_end = 1'b0; eat_sound = 1'b0;
    die_sound = 1'b0; hit_sound = 1'b0; mute = 1'b0;
    repeat (3) step();
    check_idle("reset");
    reset = 1'b0;
    step();

    // Eat sequence
    eat_sound = 1'b1;
    step();
    check_eq("eat_busy", int'(busy), 1);
    check_eq("eat_id", int'(sound_id), 1);
    measure_toggle(n); check_eq("eat_n0_a", n, 74);
    measure_toggle(n); check_eq("eat_n0_b", n, 74);
    next_note();
    measure_toggle(n); check_eq("eat_n1", n, 59);
    eat_sound = 1'b0;
    next_note();
    measure_toggle(n); check_eq("eat_n2", n, 49);
    next_note();
    saw_high = 1'b0;
    repeat (200) step();
    check_eq("eat_rest", int'(saw_high), 0);
    frame_pulses(1, 3);
    check_eq("eat_busy7", int'(busy), 1);
    frame_pulses(1, 0);
    check_idle("eat_end");

    // Held level: one sequence only
    eat_sound = 1'b1;
    step();
    check_eq("held_id", int'(sound_id), 1);
    frame_pulses(7, 3);
    check_eq("held_busy7", int'(busy), 1);
    frame_pulses(1, 3);
    check_eq("held_end", int'(busy), 0);
    repeat (50) step();
    check_eq("held_norestart", int'(busy), 0);
    eat_sound = 1'b0;
    step();

    // Simultaneous edges -> die, then dropped eat edge
    eat_sound = 1'b1; hit_sound = 1'b1; die_sound = 1'b1;
    step();
    check_eq("sim_id", int'(sound_id), 3);
    check_eq("sim_busy", int'(busy), 1);
    eat_sound = 1'b0; hit_sound = 1'b0; die_sound = 1'b0;
    measure_toggle(n); check_eq("die_n0", n, 98);
    eat_sound = 1'b1;
    step();
    check_eq("drop_eat_id", int'(sound_id), 3);
    eat_sound = 1'b0;
    next_note();
    measure_toggle(n); check_eq("die_n1", n, 110);
    next_note();
    measure_toggle(n); check_eq("die_n2", n, 131);
    next_note();
    measure_toggle(n); check_eq("die_n3", n, 166);
    frame_pulses(1, 3);
    check_eq("die_busy7", int'(busy), 1);
    check_eq("die_id7", int'(sound_id), 3);
    frame_pulses(1, 0);
    check_idle("die_end");

    // Eat preempted by hit
    eat_sound = 1'b1;
    step();
    check_eq("pre_eat_id", int'(sound_id), 1);
    eat_sound = 1'b0;
    repeat (30) step();
    hit_sound = 1'b1;
    step();
    check_eq("pre_hit_id", int'(sound_id), 2);
    check_eq("pre_hit_snd", int'(sound), 0);
    hit_sound = 1'b0;
    measure_toggle(n); check_eq("hit_n0", n, 110);

    // Mute during hit note 0; tone phase keeps running underneath
    mute = 1'b1;
    step();
    check_eq("mute_snd", int'(sound), 0);
    saw_high = 1'b0;
    repeat (49) step();
    check_eq("mute_quiet", int'(saw_high), 0);
    mute = 1'b0;
    step();
    check_eq("unmute_snd", int'(sound), 1);
    measure_toggle(n); check_eq("mute_phase", n, 59);
    mute = 1'b1;
    step();
    saw_high = 1'b0;
    frame_pulses(7, 150);
    check_eq("mute_busy7", int'(busy), 1);
    check_eq("mute_id7", int'(sound_id), 2);
    frame_pulses(1, 0);
    check_eq("mute_end", int'(busy), 0);
    check_eq("mute_all_quiet", int'(saw_high), 0);
    mute = 1'b0;
    step();

    // Reset during die note 2
    die_sound = 1'b1;
    step();
    check_eq("rst_die_id", int'(sound_id), 3);
    die_sound = 1'b0;
    next_note();
    next_note();
    measure_toggle(n); check_eq("rst_die_n2", n, 131);
    reset = 1'b1;
    step();
    check_idle("midrst");
    reset = 1'b0;
    step();
    eat_sound = 1'b1;
    step();
    check_eq("post_rst_id", int'(sound_id), 1);
    check_eq("post_rst_busy", int'(busy), 1);
    measure_toggle(n); check_eq("post_rst_n0", n, 74);
    eat_sound = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
